// File: rtl/clock_ctrl.sv
// clock_ctrl
// ----------
// Time-of-day controller for the digital clock. Divides in_clk down to a
// one-second tick, runs the cascaded seconds/minutes/hours counters
// (00:00:00 .. 23:59:59) and hosts the RUN / SET_HOUR / SET_MIN mode FSM
// that lets the user set hours and minutes with two buttons. The BCD digits
// are registered and drive the display decoders directly.
//
// Parameters:
//   TICK_DIV  in_clk cycles per one-second tick (even, >= 4)
//
// Ports:
//   in_clk    system clock, all state changes on its rising edge
//   rst       synchronous active-high reset
//   mode_btn  debounced level; rising edge advances the mode
//   inc_btn   debounced level; rising edge increments the selected field
//   mode      2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN
//   sec_tick  one-cycle pulse in the first cycle a new seconds value shows
//   h10..s1   BCD digits of hours, minutes and seconds
//
// Build option:
//   CLOCK_CTRL_BLINK_EN  when defined, the field being set blinks (4'hF is
//                        the blank code) with a half period of TICK_DIV/2.

module clock_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic [3:0] h10,
    output logic [3:0] h1,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1
);

    localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    hh, hh_n;
    logic [7:0]    mm, mm_n;
    logic [7:0]    ss, ss_n;
    logic          tick_n;
    logic          mode_hist, inc_hist;
    logic          mode_edge, inc_edge;

    // Seconds/minutes share one BCD incrementer that wraps 59 -> 00.
    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Hours wrap 23 -> 00 rather than at a digit boundary.
    function automatic logic [7:0] bcd24_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign mode_edge = mode_btn & ~mode_hist;
    assign inc_edge  = inc_btn & ~inc_hist;

    // Next-state logic for the mode FSM, the prescaler and the time fields.
    // A mode edge always takes priority, so a simultaneous inc edge is
    // dropped and a tick coinciding with entry to SET_HOUR is discarded.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hh_n    = hh;
        mm_n    = mm;
        ss_n    = ss;
        tick_n  = 1'b0;
        case (state)
            RUN: begin
                if (mode_edge) begin
                    state_n = SET_HOUR;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    ss_n   = bcd60_inc(ss);
                    if (ss == 8'h59) begin
                        mm_n = bcd60_inc(mm);
                        if (mm == 8'h59) begin
                            hh_n = bcd24_inc(hh);
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SET_HOUR: begin
                cnt_n = '0;
                if (mode_edge) begin
                    state_n = SET_MIN;
                end else if (inc_edge) begin
                    hh_n = bcd24_inc(hh);
                end
            end
            SET_MIN: begin
                cnt_n = '0;
                if (mode_edge) begin
                    state_n = RUN;
                    ss_n    = 8'h00;
                end else if (inc_edge) begin
                    mm_n = bcd60_inc(mm);
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // State register. Button history follows the inputs even during reset so
    // that a button held through reset does not register as an edge.
    always_ff @(posedge in_clk) begin
        mode_hist <= mode_btn;
        inc_hist  <= inc_btn;
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hh       <= hh_n;
            mm       <= mm_n;
            ss       <= ss_n;
            sec_tick <= tick_n;
        end
    end

    assign mode = state;
    assign s10  = ss[7:4];
    assign s1   = ss[3:0];

`ifdef CLOCK_CTRL_BLINK_EN
    localparam int            HALF     = TICK_DIV / 2;
    localparam int            BW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          show, show_n;
    logic          blink_restart;
    logic [7:0]    disp_hh, disp_mm;

    // Restart the blink phase with the value visible whenever a SET state is
    // entered or an inc is accepted, so the user sees the new value at once.
    assign blink_restart = ((state_n == SET_HOUR || state_n == SET_MIN) && state_n != state)
                         || ((state == SET_HOUR || state == SET_MIN) && inc_edge && !mode_edge);

    // Free-running half-period counter toggling the show phase.
    always_comb begin
        blink_cnt_n = blink_cnt + BW'(1);
        show_n      = show;
        if (blink_restart) begin
            blink_cnt_n = '0;
            show_n      = 1'b1;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt_n = '0;
            show_n      = ~show;
        end
    end

    // Display registers for hours/minutes, blanked from next-state values so
    // the blanked digits stay aligned with the stored time.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            blink_cnt <= '0;
            show      <= 1'b1;
            disp_hh   <= 8'h00;
            disp_mm   <= 8'h00;
        end else begin
            blink_cnt <= blink_cnt_n;
            show      <= show_n;
            disp_hh   <= (state_n == SET_HOUR && !show_n) ? 8'hFF : hh_n;
            disp_mm   <= (state_n == SET_MIN  && !show_n) ? 8'hFF : mm_n;
        end
    end

    assign h10 = disp_hh[7:4];
    assign h1  = disp_hh[3:0];
    assign m10 = disp_mm[7:4];
    assign m1  = disp_mm[3:0];
`else
    assign h10 = hh[7:4];
    assign h1  = hh[3:0];
    assign m10 = mm[7:4];
    assign m1  = mm[3:0];
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl
// -------------
// Self-checking bench for clock_ctrl with TICK_DIV=4. A reference model
// keeps the time of day as a plain seconds count and derives the expected
// digits arithmetically; a vector table and hand-written sequences add
// fixed expectations for the corner cases, followed by random button and
// reset traffic against the model.

module tb_clock_ctrl;

    localparam int TD = 4;

    logic       in_clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [1:0] mode;
    logic       sec_tick;
    logic [3:0] h10, h1, m10, m1, s10, s1;
    logic [26:0] dutPack;

    int checks = 0;
    int errors = 0;

    // Reference model state: time of day in seconds, mode number,
    // prescaler phase, blink age (cycles since the last blink restart).
    int mTod, mMode, mCnt, mAge;
    bit mTick, mHistM, mHistI;

    typedef struct {
        bit r, mb, ib;
        int md;
        bit tk;
        int hh, mm, ss;
    } vec_t;

    vec_t tbl[28];

    clock_ctrl #(.TICK_DIV(TD)) dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .mode_btn(mode_btn),
        .inc_btn (inc_btn),
        .mode    (mode),
        .sec_tick(sec_tick),
        .h10     (h10),
        .h1      (h1),
        .m10     (m10),
        .m1      (m1),
        .s10     (s10),
        .s1      (s1)
    );

    always #5 in_clk = ~in_clk;

    assign dutPack = {mode, sec_tick, h10, h1, m10, m1, s10, s1};

    function automatic logic [26:0] packExp(int md, bit tk, int hh, int mm, int ss);
        logic [26:0] e;
        e[26:25] = 2'(md);
        e[24]    = tk;
        e[23:20] = 4'(hh / 10);
        e[19:16] = 4'(hh % 10);
        e[15:12] = 4'(mm / 10);
        e[11:8]  = 4'(mm % 10);
        e[7:4]   = 4'(ss / 10);
        e[3:0]   = 4'(ss % 10);
        return e;
    endfunction

    function automatic logic [26:0] modelExp();
        logic [26:0] e;
        e = packExp(mMode, mTick, mTod / 3600, (mTod / 60) % 60, mTod % 60);
`ifdef CLOCK_CTRL_BLINK_EN
        if (((mAge / (TD / 2)) % 2) != 0) begin
            if (mMode == 1) e[23:16] = 8'hFF;
            if (mMode == 2) e[15:8]  = 8'hFF;
        end
`endif
        return e;
    endfunction

    task automatic modelStep(input bit r, input bit mb, input bit ib);
        bit me, ie;
        int h, m;
        if (r) begin
            mTod = 0; mMode = 0; mCnt = 0; mTick = 0; mAge = 0;
            mHistM = mb; mHistI = ib;
            return;
        end
        me = mb && !mHistM;
        ie = ib && !mHistI;
        mHistM = mb;
        mHistI = ib;
        mTick = 0;
        mAge++;
        if (mMode == 0) begin
            if (me) begin
                mMode = 1; mCnt = 0; mAge = 0;
            end else if (mCnt == TD - 1) begin
                mCnt = 0; mTick = 1; mTod = (mTod + 1) % 86400;
            end else begin
                mCnt++;
            end
        end else if (mMode == 1) begin
            mCnt = 0;
            if (me) begin
                mMode = 2; mAge = 0;
            end else if (ie) begin
                h = (mTod / 3600 + 1) % 24;
                mTod = h * 3600 + mTod % 3600;
                mAge = 0;
            end
        end else begin
            mCnt = 0;
            if (me) begin
                mMode = 0;
                mTod = mTod - mTod % 60;
            end else if (ie) begin
                m = ((mTod / 60) % 60 + 1) % 60;
                mTod = (mTod / 3600) * 3600 + m * 60 + mTod % 60;
                mAge = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [26:0] exp);
        checks++;
        if (dutPack !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, dutPack, exp, $time);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare after the edge.
    task automatic applyStimulus(input bit r, input bit mb, input bit ib, input string name);
        rst      = r;
        mode_btn = mb;
        inc_btn  = ib;
        @(posedge in_clk);
        modelStep(r, mb, ib);
        #1;
        checkOutput(name, modelExp());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, "idle_model");
    endtask

    task automatic pressMode();
        applyStimulus(0, 1, 0, "mode_press");
        applyStimulus(0, 0, 0, "mode_release");
    endtask

    task automatic pressInc(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 1, "inc_press");
            applyStimulus(0, 0, 0, "inc_release");
        end
    endtask

    initial begin
        int k;
        int found;

        // rst, mode_btn, inc_btn, mode, tick, hh, mm, ss
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 1, 1, 0, 1, 0, 1};
        tbl[8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 1, 1, 0, 2, 0, 1};
        tbl[10] = '{0, 0, 0, 1, 0, 2, 0, 1};
        tbl[11] = '{0, 1, 1, 2, 0, 2, 0, 1};
        tbl[12] = '{0, 0, 0, 2, 0, 2, 0, 1};
        tbl[13] = '{0, 0, 1, 2, 0, 2, 1, 1};
        tbl[14] = '{0, 0, 0, 2, 0, 2, 1, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 2, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 2, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 2, 1, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 2, 1, 0};
        tbl[19] = '{0, 0, 0, 0, 1, 2, 1, 1};
        tbl[20] = '{0, 0, 0, 0, 0, 2, 1, 1};
        tbl[21] = '{0, 1, 0, 1, 0, 2, 1, 1};
        tbl[22] = '{0, 0, 0, 1, 0, 2, 1, 1};
        tbl[23] = '{0, 1, 0, 2, 0, 2, 1, 1};
        tbl[24] = '{0, 0, 1, 2, 0, 2, 2, 1};
        tbl[25] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[26] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0};

        $display("[TB] vector table");
        for (int i = 0; i < 28; i++) begin
            applyStimulus(tbl[i].r, tbl[i].mb, tbl[i].ib, "table_model");
            checkOutput($sformatf("table_row%0d", i),
                        packExp(tbl[i].md, tbl[i].tk, tbl[i].hh, tbl[i].mm, tbl[i].ss));
        end

        $display("[TB] 240 edges from reset");
        applyStimulus(1, 0, 0, "reset");
        for (int i = 1; i <= 240; i++) begin
            applyStimulus(0, 0, 0, "run_model");
            if (i == 4)   checkOutput("first_second", packExp(0, 1, 0, 0, 1));
            if (i == 240) checkOutput("first_minute", packExp(0, 1, 0, 1, 0));
        end

        $display("[TB] preload 23:59:59 and wrap");
        pressMode();
        pressInc(23);
        checkOutput("hour_23", packExp(1, 0, 23, 1, 0));
        pressInc(1);
        checkOutput("hour_wrap", packExp(1, 0, 0, 1, 0));
        pressInc(23);
        pressMode();
        pressInc(58);
        checkOutput("min_59", packExp(2, 0, 23, 59, 0));
        pressInc(1);
        checkOutput("min_wrap_no_carry", packExp(2, 0, 23, 0, 0));
        pressInc(59);
        pressMode();
        idle(59 * TD - 1);
        checkOutput("at_235959", packExp(0, 1, 23, 59, 59));
        idle(TD);
        checkOutput("midnight_wrap", packExp(0, 1, 0, 0, 0));

        $display("[TB] held mode button");
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, "mode_held");
        checkValue("mode_held_one_step", int'(mode), 1);
        applyStimulus(0, 0, 0, "mode_held_release");

        pressInc(1);
`ifdef CLOCK_CTRL_BLINK_EN
        idle(1);
        checkValue("blink_blank", int'({h10, h1}), 8'hFF);
        idle(2);
        checkValue("blink_show", int'({h10, h1}), 8'h01);
`endif
        pressInc(11);
        pressMode();
        pressInc(34);
        pressMode();
        idle(56 * TD - 1);
        checkOutput("at_123456", packExp(0, 1, 12, 34, 56));

        $display("[TB] three mode presses from 12:34:56");
        applyStimulus(0, 1, 0, "p1");
        applyStimulus(0, 0, 0, "r1");
        applyStimulus(0, 1, 0, "p2");
        applyStimulus(0, 0, 0, "r2");
        applyStimulus(0, 1, 0, "p3");
        checkOutput("back_to_run", packExp(0, 0, 12, 34, 0));
        found = -1;
        for (k = 1; k <= TD + 2; k++) begin
            applyStimulus(0, 0, 0, "after_return");
            if (sec_tick === 1'b1) begin
                found = k;
                break;
            end
        end
        checkValue("tick_latency", found, TD);
        checkValue("first_second_after_set", int'(s1), 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 2) == 0,
                          "random_model");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
